// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - registered VGA test-pattern generator with frame-latched mode and scroll
module vga_pattern_gen #(
  parameter int RW           = 3,
  parameter int GW           = 3,
  parameter int BW           = 2,
  parameter int STRIPE_SHIFT = 4,
  parameter int SCROLL_DIV   = 2
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          vidon,
  input  logic [9:0]    hc,
  input  logic [9:0]    vc,
  input  logic [1:0]    mode,
  output logic [RW-1:0] red,
  output logic [GW-1:0] green,
  output logic [BW-1:0] blue,
  output logic          frame_start
);

  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(SCROLL_DIV - 1);

  logic          org;
  logic          org_q;
  logic [1:0]    mode_q;
  logic [FW-1:0] fcnt;
  logic [9:0]    offset;
  logic [9:0]    sv;
  logic          s;

  assign org         = (hc == 10'd0) && (vc == 10'd0);
  assign frame_start = org && !org_q;
  assign sv          = vc + offset;

  always_comb begin
    s = 1'b0;
    case (mode_q)
      2'd0:    s = vc[STRIPE_SHIFT];
      2'd1:    s = hc[STRIPE_SHIFT];
      2'd2:    s = hc[STRIPE_SHIFT] ^ vc[STRIPE_SHIFT];
      default: s = sv[STRIPE_SHIFT];
    endcase
  end

  // org_q resets high so an origin already present at release does not pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      org_q  <= 1'b1;
      mode_q <= 2'd0;
      fcnt   <= '0;
      offset <= 10'd0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else begin
      org_q <= org;
      if (frame_start) begin
        mode_q <= mode;
        if (fcnt == FCNT_LAST) begin
          fcnt   <= '0;
          offset <= offset + 10'd1;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
      red   <= vidon ? {RW{s}}  : '0;
      green <= vidon ? {GW{~s}} : '0;
      blue  <= '0;
    end
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised, registered test-pattern generator for the 640x480 VGA path. It sits between the sync/counter block (which supplies `vidon`, `hc`, `vc`) and the colour DAC pins, and adds vertical, checkerboard and frame-rate scrolling patterns to the basic horizontal stripe. Mode changes are latched only at frame start, so a frame never shows a mid-frame pattern change.

## Interface
- `RW`, 3: red channel width.
- `GW`, 3: green channel width.
- `BW`, 2: blue channel width.
- `STRIPE_SHIFT`, 4: stripe/check size is 2^STRIPE_SHIFT pixels or lines; legal range 0..9.
- `SCROLL_DIV`, 2: frames per one-line scroll step; legal range >= 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `vidon`  in  1  visible-region flag from the sync block.
- `hc`  in  10  horizontal pixel counter.
- `vc`  in  10  vertical line counter.
- `mode`  in  2  pattern select; sampled at frame start.
- `red`  out  RW  registered red.
- `green`  out  GW  registered green.
- `blue`  out  BW  registered blue.
- `frame_start`  out  1  one-`clk` pulse at frame origin.

## Operation
- Frame origin condition: `org = (hc == 0) && (vc == 0)`. `org_q` is `org` delayed one `clk`. `frame_start = org && !org_q`, combinational from registered `org_q`, so exactly one pulse per frame even when `hc`/`vc` hold for several `clk`s under a pixel enable.
- At `frame_start`: `mode_q <= mode`. The frame counter `fcnt` (width ceil(log2(SCROLL_DIV)), minimum 1) advances. When `fcnt == SCROLL_DIV-1`, it wraps to 0 and `offset` (10 bits) increments by 1, modulo 1024.
- Scrolled line index: `sv = vc + offset`, truncated to 10 bits.
- Stripe bit `s` by `mode_q`:
  - 0 (H stripes): `s = vc[STRIPE_SHIFT]`.
  - 1 (V stripes): `s = hc[STRIPE_SHIFT]`.
  - 2 (checker): `s = hc[STRIPE_SHIFT] ^ vc[STRIPE_SHIFT]`.
  - 3 (scrolling H stripes): `s = sv[STRIPE_SHIFT]`.
- Colour, registered next `clk`:
  - `vidon == 1`: `red` = all bits equal to `s`; `green` = all bits equal to `!s`; `blue` = 0.
  - `vidon == 0`: all three outputs 0.
- Reset values (`clr_n` low, asynchronous): `red`, `green`, `blue` = 0; `mode_q` = 0; `fcnt` = 0; `offset` = 0; `org_q` = 1, which suppresses a spurious `frame_start` if `hc`/`vc` are at 0 when reset releases. The first pulse therefore comes at the next true origin entry.
- Reset mid-frame: outputs blank immediately and the scroll phase restarts at 0. After release, the pattern runs in mode 0 until the next `frame_start`.
- `frame_start` with `SCROLL_DIV == 1`: `offset` increments every frame.

## Timing
- Colour latency: 1 `clk` from `vidon`/`hc`/`vc` to `red`/`green`/`blue`. The sync block delays `hsync`/`vsync` by 1 `clk` to stay aligned.
- `mode_q`, `offset` and `fcnt` update on the same edge where `frame_start` is high. The pixel at the origin is coloured with the old `mode_q`/`offset`; new values apply from the next `clk`. The origin pixel is in blanking for standard timing.
- `frame_start` is a Mealy output, asserted in the same `clk` that `org` first becomes true.
- No combinational path from `mode` to the colour outputs.

## Test plan
- Reset: hold `clr_n=0` with `vidon=1`, `vc=16`. Required: RGB = 0 and `frame_start=0`. Release `clr_n` with `hc=vc=0`. Required: no `frame_start` pulse until `org` first drops and re-asserts.
- Mode 0, defaults: `vidon=1`. At `vc=15`: next-`clk` `red=000`, `green=111`. At `vc=16`: `red=111`, `green=000`, `blue=00`. With `vidon=0`: all outputs 0.
- Mode latching: drive `mode=2` mid-frame. Required: output stays in mode 0 until the next origin. Then at `hc=16`, `vc=0`: `red=111`. At `hc=16`, `vc=16`: `red=000`.
- Scrolling: `mode=3`, `SCROLL_DIV=2`, run 4 frames. Required: `offset` goes 0, 0, 1, 1, 2 across frame starts. In frame 3 at `vc=15`: `sv=16`, so `red=111`.
- Offset wrap: force 2048 frames at `SCROLL_DIV=2`. Required: `offset` returns to 0 and the stripe phase matches frame 0.
- Reset mid-frame: pulse `clr_n` low while `offset=5` and `mode_q=3`. Required: outputs 0 during reset; afterwards mode 0 pattern and `offset=0`.
